// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Reset and lock supervisor for the board clock-generation PLL. It pulses the
// PLL reset for a guaranteed minimum time, waits for the PLL to lock (with a
// timeout and a bounded number of retries), qualifies the lock as stable, and
// only then releases the downstream system reset. A lock loss while running
// restarts the whole sequence. Too many consecutive failed attempts park the
// block in a sticky fault state that only RST clears.
//
// Runs entirely on SYSCLK (200 MHz, independent of the PLL outputs).
//
// Parameters:
//   RST_PULSE_CYCLES    - cycles PLL_RST is held high per attempt (min 2)
//   LOCK_TIMEOUT_CYCLES - cycles allowed for lock after PLL_RST release
//   LOCK_STABLE_CYCLES  - consecutive locked cycles before SYS_RST release
//   MAX_RETRIES         - failed attempts tolerated before FAULT (1..15)
//
// Ports:
//   SYSCLK     in   clock, all logic on its rising edge
//   RST        in   synchronous active-high reset
//   PLL_LOCKED in   PLL lock indicator, asynchronous to SYSCLK
//   PLL_RST    out  reset to the PLL, active-high
//   SYS_RST    out  downstream reset, active-high
//   READY      out  high while running with a stable lock
//   FAULT      out  sticky, retries exhausted
//   RETRY_CNT  out  failed attempts since the last successful lock (sat. 15)
//   LOSS_CNT   out  lock-loss events while running (sat. 255)
//
// Build option:
//   PLL_RESET_SEQ_LOSS_COUNT_EN - when defined, LOSS_CNT is a real counter;
//   when undefined, no counter is built and LOSS_CNT is tied to 8'h00.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 200000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic       SYSCLK,
    input  logic       RST,
    input  logic       PLL_LOCKED,
    output logic       PLL_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    // -------------------------------------------------------------------------
    // Shared counter sizing: wide enough for the largest of the three counts.
    // -------------------------------------------------------------------------
    localparam int unsigned CNT_MAX_A =
        (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX =
        (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    // Registered output bundle, loaded from the decode of the next state so
    // every output comes straight from a flop with no input-to-output path.
    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
        logic fault;
    } out_t;

    function automatic out_t decode(input state_t s);
        out_t o;
        o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
        case (s)
            S_RESET:     o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            S_WAIT_LOCK: o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            S_STABLE:    o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            S_RUN:       o = '{pll_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1, fault: 1'b0};
            S_FAULT:     o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b1};
            default:     o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
        endcase
        return o;
    endfunction

    // -------------------------------------------------------------------------
    // Lock synchronizer: PLL_LOCKED is asynchronous, so every FSM decision
    // uses lk, which lags the pin by two SYSCLK edges.
    // -------------------------------------------------------------------------
    logic lk_meta;
    logic lk;

    always_ff @(posedge SYSCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others, independent of order.
        if (RST) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= PLL_LOCKED;
            lk      <= lk_meta;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state, shared counter, retry counter and output registers
    // -------------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       retry_cnt;
    logic [3:0]       retry_next;
    logic [3:0]       retry_inc;
    logic             fail;
    out_t             outs;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt + CNT_ONE;
        retry_next = retry_cnt;
        fail       = 1'b0;
        retry_inc  = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;

        case (state)
            S_RESET: begin
                if (cnt == PULSE_LAST) begin
                    state_next = S_WAIT_LOCK;
                end
            end

            S_WAIT_LOCK: begin
                // A lock seen on the final timeout cycle still counts as a lock.
                if (lk) begin
                    state_next = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail = 1'b1;
                end
            end

            S_STABLE: begin
                if (!lk) begin
                    fail = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_next = S_RUN;
                    retry_next = 4'd0;
                end
            end

            S_RUN: begin
                cnt_next = '0;
                // A lock loss while running restarts the sequence but is not
                // a failed attempt, so the retry budget is left alone.
                if (!lk) begin
                    state_next = S_RESET;
                end
            end

            S_FAULT: begin
                cnt_next = '0;
            end

            default: begin
                state_next = S_RESET;
            end
        endcase

        // One failure per attempt, whatever combination of causes triggered it.
        if (fail) begin
            retry_next = retry_inc;
            state_next = (retry_inc >= RETRY_LIMIT) ? S_FAULT : S_RESET;
        end

        if (state_next != state) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state     <= S_RESET;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            outs      <= decode(S_RESET);
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            retry_cnt <= retry_next;
            outs      <= decode(state_next);
        end
    end

    assign PLL_RST   = outs.pll_rst;
    assign SYS_RST   = outs.sys_rst;
    assign READY     = outs.ready;
    assign FAULT     = outs.fault;
    assign RETRY_CNT = retry_cnt;

    // -------------------------------------------------------------------------
    // Optional lock-loss counter
    // -------------------------------------------------------------------------
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_cnt;
    logic       loss_event;

    // Same condition that sends the FSM from S_RUN back to S_RESET.
    assign loss_event = (state == S_RUN) && !lk;

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            loss_cnt <= 8'h00;
        end else if (loss_event && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'h01;
        end
    end

    assign LOSS_CNT = loss_cnt;
`else
    assign LOSS_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with RST_PULSE_CYCLES=4,
// LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3.
// Inputs are driven and outputs sampled 1 time unit after a rising edge.
// Edge bookkeeping used for the expected values: a PLL_LOCKED change made
// after edge n is seen as lk after edge n+2 and acted on by the FSM at edge
// n+3; the counter restarts at 0 on every state change.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    logic       SYSCLK;
    logic       RST;
    logic       PLL_LOCKED;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int compared   = 0;
    int mismatched = 0;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam logic [7:0] LOSS_AFTER_ONE = 8'd1;
`else
    localparam logic [7:0] LOSS_AFTER_ONE = 8'd0;
`endif

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (3)
    ) dut (
        .SYSCLK    (SYSCLK),
        .RST       (RST),
        .PLL_LOCKED(PLL_LOCKED),
        .PLL_RST   (pll_rst),
        .SYS_RST   (sys_rst),
        .READY     (ready),
        .FAULT     (fault),
        .RETRY_CNT (retry_cnt),
        .LOSS_CNT  (loss_cnt)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic step(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        RST        = 1'b1;
        PLL_LOCKED = 1'b0;

        // ---------------- 1. reset state and nominal lock ----------------
        step(1);                                   // e0
        check("rst_pll_rst",   pll_rst,   8'd1);
        check("rst_sys_rst",   sys_rst,   8'd1);
        check("rst_ready",     ready,     8'd0);
        check("rst_fault",     fault,     8'd0);
        check("rst_retry",     retry_cnt, 8'd0);
        check("rst_loss",      loss_cnt,  8'd0);
        step(2);                                   // e2, RST held 3 edges
        RST = 1'b0;
        step(3);                                   // e5: pulse cycles 1..3
        check("nom_pulse_hold", pll_rst, 8'd1);
        step(1);                                   // e6: 4 cycles done
        check("nom_pulse_end",  pll_rst, 8'd0);
        check("nom_wait_sys",   sys_rst, 8'd1);
        step(10);                                  // e16
        PLL_LOCKED = 1'b1;
        step(10);                                  // e26: last STABLE cycle
        check("nom_pre_run_sys",   sys_rst, 8'd1);
        check("nom_pre_run_ready", ready,   8'd0);
        step(1);                                   // e27: S_RUN
        check("nom_run_sys",   sys_rst,   8'd0);
        check("nom_run_ready", ready,     8'd1);
        check("nom_run_pll",   pll_rst,   8'd0);
        check("nom_run_retry", retry_cnt, 8'd0);

        // ---------------- 2. timeout then retry ----------------
        RST        = 1'b1;
        PLL_LOCKED = 1'b0;
        step(1);                                   // r0
        check("rty_rst_pll",   pll_rst, 8'd1);
        check("rty_rst_ready", ready,   8'd0);
        RST = 1'b0;
        step(4);                                   // r4: S_WAIT_LOCK
        check("rty_release", pll_rst, 8'd0);
        step(19);                                  // r23: last timeout cycle
        check("rty_pre_to_pll",   pll_rst,   8'd0);
        check("rty_pre_to_retry", retry_cnt, 8'd0);
        step(1);                                   // r24: timeout
        check("rty_to_pll",   pll_rst,   8'd1);
        check("rty_to_retry", retry_cnt, 8'd1);
        step(3);                                   // r27
        check("rty_pulse_hold", pll_rst, 8'd1);
        step(1);                                   // r28: second release
        check("rty_pulse_end", pll_rst,   8'd0);
        check("rty_wait_retry", retry_cnt, 8'd1);
        PLL_LOCKED = 1'b1;
        step(10);                                  // r38
        check("rty_stable_retry", retry_cnt, 8'd1);
        check("rty_stable_sys",   sys_rst,   8'd1);
        step(1);                                   // r39: S_RUN
        check("rty_run_retry", retry_cnt, 8'd0);
        check("rty_run_ready", ready,     8'd1);
        check("rty_run_sys",   sys_rst,   8'd0);

        // ---------------- 5. lock loss while running ----------------
        PLL_LOCKED = 1'b0;
        step(2);                                   // r41: lk just fell
        check("loss_pre_ready", ready,   8'd1);
        check("loss_pre_sys",   sys_rst, 8'd0);
        step(1);                                   // r42: S_RESET
        check("loss_ready", ready,     8'd0);
        check("loss_sys",   sys_rst,   8'd1);
        check("loss_pll",   pll_rst,   8'd1);
        check("loss_cnt",   loss_cnt,  LOSS_AFTER_ONE);
        check("loss_retry", retry_cnt, 8'd0);

        // ---------------- 4. glitch during qualification ----------------
        PLL_LOCKED = 1'b1;
        for (int i = 0; i < 8; i++) begin          // r43..r50
            step(1);
            check("glt_sys_hold", sys_rst, 8'd1);
        end
        check("glt_stable_pll", pll_rst, 8'd0);    // r50: S_STABLE, cnt 3
        PLL_LOCKED = 1'b0;
        step(1);                                   // r51
        PLL_LOCKED = 1'b1;
        check("glt_sys_hold", sys_rst, 8'd1);
        step(1);                                   // r52: cnt 5, lk now 0
        check("glt_pre_pll",   pll_rst,   8'd0);
        check("glt_pre_retry", retry_cnt, 8'd0);
        check("glt_sys_hold",  sys_rst,   8'd1);
        step(1);                                   // r53: failure
        check("glt_pll",   pll_rst,   8'd1);
        check("glt_retry", retry_cnt, 8'd1);
        check("glt_sys",   sys_rst,   8'd1);

        // ---------------- 6. mid-operation reset in S_STABLE ----------------
        step(4);                                   // r57: S_WAIT_LOCK
        check("mid_wait_pll", pll_rst, 8'd0);
        step(2);                                   // r59: S_STABLE, cnt 1
        check("mid_stable_pll",   pll_rst,   8'd0);
        check("mid_stable_retry", retry_cnt, 8'd1);
        RST = 1'b1;
        step(1);                                   // r60
        check("mid_pll",   pll_rst,   8'd1);
        check("mid_sys",   sys_rst,   8'd1);
        check("mid_retry", retry_cnt, 8'd0);
        check("mid_loss",  loss_cnt,  8'd0);

        // ---------------- 3. fault after three timeouts ----------------
        RST        = 1'b0;
        PLL_LOCKED = 1'b0;
        step(24);                                  // r84: first timeout
        check("flt_1_retry", retry_cnt, 8'd1);
        check("flt_1_pll",   pll_rst,   8'd1);
        check("flt_1_fault", fault,     8'd0);
        step(47);                                  // r131: third wait, last cycle
        check("flt_pre_retry", retry_cnt, 8'd2);
        check("flt_pre_pll",   pll_rst,   8'd0);
        check("flt_pre_fault", fault,     8'd0);
        step(1);                                   // r132: third timeout
        check("flt_fault", fault,     8'd1);
        check("flt_pll",   pll_rst,   8'd1);
        check("flt_sys",   sys_rst,   8'd1);
        check("flt_ready", ready,     8'd0);
        check("flt_retry", retry_cnt, 8'd3);
        PLL_LOCKED = 1'b1;                         // lock must not leave S_FAULT
        step(120);
        check("flt_hold_fault", fault,     8'd1);
        check("flt_hold_pll",   pll_rst,   8'd1);
        check("flt_hold_sys",   sys_rst,   8'd1);
        check("flt_hold_retry", retry_cnt, 8'd3);
        RST        = 1'b1;
        PLL_LOCKED = 1'b0;
        step(1);                                   // f0
        check("flt_clr_fault", fault,     8'd0);
        check("flt_clr_retry", retry_cnt, 8'd0);
        check("flt_clr_pll",   pll_rst,   8'd1);

        // ---------------- lock on the last timeout cycle ----------------
        RST = 1'b0;
        step(4);                                   // f4: S_WAIT_LOCK, cnt 0
        check("edge_wait_pll", pll_rst, 8'd0);
        step(17);                                  // f21
        PLL_LOCKED = 1'b1;                         // lk high at f23, cnt 19
        step(3);                                   // f24: lock wins
        check("edge_lock_pll",   pll_rst,   8'd0);
        check("edge_lock_retry", retry_cnt, 8'd0);
        step(8);                                   // f32: S_RUN
        check("edge_run_ready", ready,   8'd1);
        check("edge_run_sys",   sys_rst, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
